// File: rtl/fa_serial_sched.sv
// fa_serial_sched: bit-serial add/subtract engine built around one shared
// full-adder cell. It arbitrates round-robin between two requesters, captures
// the winner's operands and runs one bit per clock, LSB first. After WIDTH
// cycles it presents RESULT, carry-out and two's-complement overflow for one
// DONE cycle.

// Single full-adder cell shared by both requesters.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

module fa_serial_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             sub0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub1,
  output logic             gnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic             fa_sum;
  logic             fa_co;
  logic             any_req;
  logic             win;
  logic             capture;
  logic             last_bit;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sub;

  // Round-robin: a lone request wins outright; with both pending the
  // requester that was not served last time wins.
  assign any_req  = req0 | req1;
  assign win      = (req0 && req1) ? ~last : req1;
  assign sel_a    = win ? a1 : a0;
  assign sel_b    = win ? b1 : b0;
  assign sel_sub  = win ? sub1 : sub0;
  assign capture  = (state == IDLE) && any_req;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  fa_cell u_fa (
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .ci  (carry),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on a request, RUN for WIDTH bits, one FIN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: grant, round-robin pointer, bit counter, BUSY and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= 1'b0;
      last <= 1'b1;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == RUN) && last_bit;
      if (capture) begin
        gnt  <= win;
        last <= win;
        cnt  <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Result shift register and flags; the final carry and the MSB carry-in
  // (still in 'carry' on the last bit) give CO and OVF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else if (capture) begin
      result <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == RUN) begin
      result <= {fa_sum, result[WIDTH-1:1]};
      if (last_bit) begin
        co  <= fa_co;
        ovf <= carry ^ fa_co;
      end
    end
  end

  // Operand shifters and running carry; subtraction is A + ~B + 1.
  always_ff @(posedge clk) begin
    if (capture) begin
      sh_a  <= sel_a;
      sh_b  <= sel_sub ? ~sel_b : sel_b;
      carry <= sel_sub;
    end else if (state == RUN) begin
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      carry <= fa_co;
    end
  end

endmodule

// File: tb/tb_fa_serial_sched.sv
// Testbench for fa_serial_sched: requester stimulus pushes expected results
// into a queue; a monitor pops and compares on every DONE pulse.
module tb_fa_serial_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic         sub0 = 1'b0;
  logic         sub1 = 1'b0;
  logic [W-1:0] a0 = '0;
  logic [W-1:0] b0 = '0;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] b1 = '0;
  logic         gnt;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         co;
  logic         ovf;

  fa_serial_sched #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .sub0   (sub0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .sub1   (sub1),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .co     (co),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         g;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    int unsigned  cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic        mlast = 1'b1;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from plain integer math.
  function automatic exp_t model(input logic g, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int unsigned c);
    exp_t        e;
    int          sa;
    int          sb;
    int          r;
    int unsigned ua;
    int unsigned ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = a;
    ub = b;
    if (s) begin
      r   = sa - sb;
      e.c = (ua >= ub);
      e.r = W'(ua - ub);
    end else begin
      r   = sa + sb;
      e.c = ((ua + ub) >= (32'd1 << W));
      e.r = W'(ua + ub);
    end
    e.v   = (r > ((1 << (W - 1)) - 1)) || (r < -(1 << (W - 1)));
    e.g   = g;
    e.cyc = c;
    return e;
  endfunction

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
      chk("expected_pending", {31'd0, (q.size() > 0)}, 32'd1);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("gnt", {31'd0, gnt}, {31'd0, me.g});
        chk("result", {24'd0, result}, {24'd0, me.r});
        chk("co", {31'd0, co}, {31'd0, me.c});
        chk("ovf", {31'd0, ovf}, {31'd0, me.v});
        chk("done_latency", cyc, me.cyc);
      end
    end
    prev_done = done;
  end

  // One scheduling slot starting in an IDLE cycle. Mode per requester:
  // 0 = maybe assert (random), 1 = assert if low, 2 = leave low.
  task automatic slot(input int m0, input logic [W-1:0] da0, input logic [W-1:0] db0, input logic ds0,
                      input int m1, input logic [W-1:0] da1, input logic [W-1:0] db1, input logic ds1,
                      input bit mid);
    logic w;
    exp_t e;
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    if (!req0 && (m0 == 1 || (m0 == 0 && $urandom_range(0, 1) == 1))) begin
      req0 = 1'b1; a0 = da0; b0 = db0; sub0 = ds0;
    end
    if (!req1 && (m1 == 1 || (m1 == 0 && $urandom_range(0, 1) == 1))) begin
      req1 = 1'b1; a1 = da1; b1 = db1; sub1 = ds1;
    end
    if (!req0 && !req1) return;
    w = (req0 && req1) ? ~mlast : req1;
    mlast = w;
    if (w) e = model(1'b1, a1, b1, sub1, cyc + 1 + W);
    else   e = model(1'b0, a0, b0, sub0, cyc + 1 + W);
    q.push_back(e);
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_run", {31'd0, busy}, 32'd1);
      if (mid && k == 2) begin
        if (w) begin a1 = 8'hFF; b1 = 8'hFF; sub1 = 1'b1; end
        else   begin a0 = 8'hFF; b0 = 8'hFF; sub0 = 1'b1; end
      end
      if (mid && k == 3) begin
        if (w && !req0) begin
          req0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom); sub0 = 1'($urandom);
        end else if (!w && !req1) begin
          req1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom); sub1 = 1'($urandom);
        end
      end
      if (k == W + 1) begin
        chk("done_in_done_cycle", {31'd0, done}, 32'd1);
        if (w) req1 = 1'b0;
        else   req0 = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", {31'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_co", {31'd0, co}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;

    slot(1, 8'h7F, 8'h01, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b0);
    slot(2, 8'h00, 8'h00, 1'b0, 1, 8'h05, 8'h07, 1'b1, 1'b0);
    slot(1, 8'h80, 8'h01, 1'b1, 2, 8'h00, 8'h00, 1'b0, 1'b0);
    slot(1, 8'hFF, 8'h01, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b0);
    slot(1, 8'h00, 8'h00, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b0);

    // Both requesters continuously re-asserting: grants alternate.
    for (int i = 0; i < 4; i++)
      slot(1, W'($urandom), W'($urandom), 1'($urandom), 1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    // Drain whichever requester is still pending.
    slot(2, 8'h00, 8'h00, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    req0 = 1'b1; a0 = 8'h12; b0 = 8'h34; sub0 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gnt", {31'd0, gnt}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", {24'd0, result}, 32'd0);
    chk("midrst_co", {31'd0, co}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    mlast = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    slot(1, 8'h12, 8'h34, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b0);

    // Operand changes during RUN are ignored; requester 1 arrives mid-run.
    slot(1, 8'h10, 8'h20, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b1);
    slot(2, 8'h00, 8'h00, 1'b0, 1, 8'h00, 8'h00, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++)
      slot(0, W'($urandom), W'($urandom), 1'($urandom), 0, W'($urandom), W'($urandom), 1'($urandom),
           1'($urandom));
    slot(2, 8'h00, 8'h00, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b0);
    slot(2, 8'h00, 8'h00, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
